bcd_seq_converter: RTL

Multi-cycle, handshaked signed binary-to-BCD converter for the signed multiplier's display path. It accepts a two's-complement product and splits it into sign and magnitude. The magnitude is converted with the shift-and-add-3 (double-dabble) algorithm, one bit per clock, on a single shared digit datapath. This replaces the fully unrolled combinational converter and removes its long combinational path between the multiplier output and the display driver.

---
 rtl/bcd_seq_converter.sv | 117 +++++++++++
 1 files changed

// File: rtl/bcd_seq_converter.sv
// Sequential signed binary-to-BCD converter: sign/magnitude split, then one
// double-dabble step per clock on a single shared digit datapath.
module bcd_seq_converter #(
    parameter int unsigned BIN_W  = 15,
    parameter int unsigned DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W:0]        bin,
    output logic                  busy,
    output logic                  done,
    output logic                  sign,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int unsigned CntW = $clog2(BIN_W + 2);
    localparam int unsigned AccW = 4 * DIGITS;

    typedef enum logic [1:0] {
        StIdle,
        StConv,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic               sign_r_q, sign_r_d;
    logic [BIN_W:0]     mag_q, mag_d;
    logic [AccW-1:0]    acc_q, acc_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [AccW-1:0]    bcd_q, bcd_d;
    logic               sign_q, sign_d;

    logic [AccW-1:0]    acc_adj;
    logic [AccW-1:0]    acc_shift;
    logic [BIN_W:0]     bin_neg;

    assign bin_neg = (~bin) + {{BIN_W{1'b0}}, 1'b1};

    // All digits are corrected from the pre-adjust value in parallel.
    always_comb begin
        logic [3:0] digit;
        acc_adj = '0;
        digit   = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            digit = acc_q[4*i +: 4];
            acc_adj[4*i +: 4] = (digit >= 4'd5) ? digit + 4'd3 : digit;
        end
    end

    assign acc_shift = {acc_adj[AccW-2:0], mag_q[BIN_W]};

    always_comb begin
        state_d  = state_q;
        sign_r_d = sign_r_q;
        mag_d    = mag_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        bcd_d    = bcd_q;
        sign_d   = sign_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    sign_r_d = bin[BIN_W];
                    mag_d    = bin[BIN_W] ? bin_neg : bin;
                    acc_d    = '0;
                    cnt_d    = CntW'(BIN_W + 1);
                    state_d  = StConv;
                end
            end
            StConv: begin
                acc_d = acc_shift;
                mag_d = {mag_q[BIN_W-1:0], 1'b0};
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    // Publish only the final result so outputs never show partials.
                    bcd_d   = acc_shift;
                    sign_d  = sign_r_q;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            sign_r_q <= 1'b0;
            mag_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            bcd_q    <= '0;
            sign_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sign_r_q <= sign_r_d;
            mag_q    <= mag_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            bcd_q    <= bcd_d;
            sign_q   <= sign_d;
        end
    end

    assign busy = (state_q != StIdle);
    assign done = (state_q == StDone);
    assign sign = sign_q;
    assign bcd  = bcd_q;

endmodule
